// File: rtl/bbcore_ctrl.sv
// Command sequencer for one BitBlade compute core: streams act/weight buffer
// reads, drives the core control strobes, waits for done and hands off the psum.
module bbcore_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_Start,
  input  logic [ADDR_W-1:0] i_Len,
  input  logic [ADDR_W-1:0] i_Act_Base,
  input  logic [ADDR_W-1:0] i_W_Base,
  input  logic [1:0]        i_Act_Prec,
  input  logic [1:0]        i_W_Prec,
  input  logic              i_Stall,
  output logic              o_Rd_En,
  output logic [ADDR_W-1:0] o_Act_Addr,
  output logic [ADDR_W-1:0] o_W_Addr,
  output logic              o_Core_Vld,
  output logic              o_Sel_Bias,
  output logic              o_Flush,
  output logic [3:0]        o_Precision,
  input  logic              i_Core_Done,
  output logic              o_Psum_Vld,
  input  logic              i_Psum_Rdy,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Timeout,
  output logic              o_Err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, WAIT_DONE, OUT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, act_base_q, w_base_q, k_q;
  logic [3:0]        prec_q;
  logic [WD_W-1:0]   wd_q;
  logic              core_vld_q, sel_bias_q, flush_q, done_q, err_q, timeout_q;

  logic accept, reject, beat, last_beat, done_seen, wd_expire, handshake;

  assign accept    = (state_q == IDLE) && i_Start && (i_Len != '0);
  assign reject    = (state_q == IDLE) && i_Start && (i_Len == '0);
  assign beat      = (state_q == STREAM) && !i_Stall;
  assign last_beat = beat && (k_q == len_q - ADDR_W'(1));
  // The WAIT_DONE cycle that carries o_Flush is too early for a genuine done.
  assign done_seen = (state_q == WAIT_DONE) && i_Core_Done && !flush_q;
  assign wd_expire = (state_q == WAIT_DONE) && !done_seen && (wd_q == WD_W'(TIMEOUT - 1));
  assign handshake = (state_q == OUT) && i_Psum_Rdy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept)    state_d = STREAM;
      STREAM:    if (last_beat) state_d = FLUSH;
      FLUSH:                    state_d = WAIT_DONE;
      WAIT_DONE: if (done_seen) state_d = OUT;
                 else if (wd_expire) state_d = IDLE;
      OUT:       if (handshake) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    o_Rd_En    = beat;
    o_Busy     = (state_q != IDLE);
    o_Psum_Vld = (state_q == OUT);
    o_Act_Addr = act_base_q + k_q;
    o_W_Addr   = w_base_q + k_q;
  end

  // NOTE: every control/datapath register is reset, so outputs are all zero
  // the instant RST asserts, even mid-stream.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_q      <= '0;
      act_base_q <= '0;
      w_base_q   <= '0;
      k_q        <= '0;
      prec_q     <= '0;
      wd_q       <= '0;
      core_vld_q <= 1'b0;
      sel_bias_q <= 1'b0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      core_vld_q <= beat;
      sel_bias_q <= beat && (k_q == '0);
      flush_q    <= (state_q == FLUSH);
      done_q     <= handshake;
      err_q      <= reject;
      if (accept) begin
        len_q      <= i_Len;
        act_base_q <= i_Act_Base;
        w_base_q   <= i_W_Base;
        prec_q     <= {i_Act_Prec, i_W_Prec};
        k_q        <= '0;
        timeout_q  <= 1'b0;
      end else if (beat) begin
        k_q <= k_q + ADDR_W'(1);
      end
      if (state_q == FLUSH)          wd_q <= '0;
      else if (state_q == WAIT_DONE) wd_q <= wd_q + WD_W'(1);
      if (wd_expire) timeout_q <= 1'b1;
    end
  end

  assign o_Core_Vld  = core_vld_q;
  assign o_Sel_Bias  = sel_bias_q;
  assign o_Flush     = flush_q;
  assign o_Precision = prec_q;
  assign o_Done      = done_q;
  assign o_Err       = err_q;
  assign o_Timeout   = timeout_q;

endmodule

// File: tb/tb_bbcore_ctrl.sv
// Directed bench for bbcore_ctrl: per-cycle expected bit masks are hand-derived
// from the command timing (start accepted at edge T, cycle n = T+n).
module tb_bbcore_ctrl;

  logic       CLK, RST;
  logic       i_Start, i_Stall, i_Core_Done, i_Psum_Rdy;
  logic [9:0] i_Len, i_Act_Base, i_W_Base;
  logic [1:0] i_Act_Prec, i_W_Prec;
  logic       o_Rd_En, o_Core_Vld, o_Sel_Bias, o_Flush, o_Psum_Vld;
  logic       o_Busy, o_Done, o_Timeout, o_Err;
  logic [9:0] o_Act_Addr, o_W_Addr;
  logic [3:0] o_Precision;

  int checks = 0;
  int failures = 0;

  bbcore_ctrl #(.ADDR_W(10), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST),
    .i_Start(i_Start), .i_Len(i_Len), .i_Act_Base(i_Act_Base), .i_W_Base(i_W_Base),
    .i_Act_Prec(i_Act_Prec), .i_W_Prec(i_W_Prec), .i_Stall(i_Stall),
    .o_Rd_En(o_Rd_En), .o_Act_Addr(o_Act_Addr), .o_W_Addr(o_W_Addr),
    .o_Core_Vld(o_Core_Vld), .o_Sel_Bias(o_Sel_Bias), .o_Flush(o_Flush),
    .o_Precision(o_Precision), .i_Core_Done(i_Core_Done), .o_Psum_Vld(o_Psum_Vld),
    .i_Psum_Rdy(i_Psum_Rdy), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_Timeout(o_Timeout), .o_Err(o_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL sim_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".rd"},    32'(o_Rd_En),     0);
    check({name, ".vld"},   32'(o_Core_Vld),  0);
    check({name, ".bias"},  32'(o_Sel_Bias),  0);
    check({name, ".flush"}, 32'(o_Flush),     0);
    check({name, ".psum"},  32'(o_Psum_Vld),  0);
    check({name, ".busy"},  32'(o_Busy),      0);
    check({name, ".done"},  32'(o_Done),      0);
    check({name, ".tmo"},   32'(o_Timeout),   0);
    check({name, ".err"},   32'(o_Err),       0);
    check({name, ".prec"},  32'(o_Precision), 0);
    check({name, ".aaddr"}, 32'(o_Act_Addr),  0);
    check({name, ".waddr"}, 32'(o_W_Addr),    0);
  endtask

  // Issues one command and checks every output for cycles n=1..ncyc.
  task automatic run_cmd(input string name, input int len, input int abase, input int wbase,
                         input int aprec, input int wprec, input logic [127:0] stall_m,
                         input logic [127:0] done_m, input int rdy_at, input int ncyc,
                         input logic [127:0] rd_m, input logic [127:0] vld_m,
                         input logic [127:0] bias_m, input int flush_at,
                         input logic [127:0] psum_m, input int done_at,
                         input int busy_last, input int to_at);
    int k = 0;
    int last_rd = 0;
    for (int i = 0; i < 128; i++) if (rd_m[i]) last_rd = i;
    i_Start = 1'b1; i_Len = 10'(len); i_Act_Base = 10'(abase); i_W_Base = 10'(wbase);
    i_Act_Prec = 2'(aprec); i_W_Prec = 2'(wprec);
    tick();
    i_Start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      i_Stall = stall_m[n];
      i_Core_Done = done_m[n];
      i_Psum_Rdy = (n >= rdy_at);
      #1;
      check($sformatf("%s.rd@%0d", name, n),    32'(o_Rd_En),    32'(rd_m[n]));
      check($sformatf("%s.vld@%0d", name, n),   32'(o_Core_Vld), 32'(vld_m[n]));
      check($sformatf("%s.bias@%0d", name, n),  32'(o_Sel_Bias), 32'(bias_m[n]));
      check($sformatf("%s.flush@%0d", name, n), 32'(o_Flush),    32'(n == flush_at));
      check($sformatf("%s.psum@%0d", name, n),  32'(o_Psum_Vld), 32'(psum_m[n]));
      check($sformatf("%s.done@%0d", name, n),  32'(o_Done),     32'(n == done_at));
      check($sformatf("%s.busy@%0d", name, n),  32'(o_Busy),     32'(n <= busy_last));
      check($sformatf("%s.tmo@%0d", name, n),   32'(o_Timeout),  32'(to_at > 0 && n >= to_at));
      check($sformatf("%s.err@%0d", name, n),   32'(o_Err),      0);
      check($sformatf("%s.prec@%0d", name, n),  32'(o_Precision), 32'((aprec << 2) | wprec));
      if (n <= last_rd) begin
        check($sformatf("%s.aaddr@%0d", name, n), 32'(o_Act_Addr), 32'((abase + k) & 10'h3FF));
        check($sformatf("%s.waddr@%0d", name, n), 32'(o_W_Addr),   32'((wbase + k) & 10'h3FF));
      end
      if (rd_m[n]) k++;
      if (n < ncyc) tick();
    end
    i_Stall = 1'b0; i_Core_Done = 1'b0; i_Psum_Rdy = 1'b0;
  endtask

  initial begin
    RST = 1'b0; i_Start = 1'b0; i_Len = '0; i_Act_Base = '0; i_W_Base = '0;
    i_Act_Prec = '0; i_W_Prec = '0; i_Stall = 1'b0; i_Core_Done = 1'b0; i_Psum_Rdy = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    check_all_zero("reset");
    @(negedge CLK) RST = 1'b1;
    tick();

    // K=4 plain run; done pulses at n=3 (STREAM) and n=6 (flush cycle) must be ignored.
    run_cmd("k4", 4, 'h010, 'h200, 1, 2, '0, 128'h248, 1, 12,
            128'h1E, 128'h3C, 128'h4, 6, 128'h400, 11, 10, 0);
    tick();

    // K=3, two stall cycles after beat 0; downstream not ready for 5 cycles.
    run_cmd("stall", 3, 'h100, 'h020, 3, 0, 128'hC, 128'h200, 15, 17,
            128'h32, 128'h64, 128'h4, 7, 128'hFC00, 16, 15, 0);
    tick();

    // Address wrap at 0x3FE, then no done: watchdog fires after 64 WAIT_DONE cycles.
    run_cmd("wrap", 4, 'h3FE, 'h001, 0, 1, '0, '0, 200, 72,
            128'h1E, 128'h3C, 128'h4, 6, '0, 0, 69, 70);
    check("wrap.aaddr_end", 32'(o_Act_Addr), 32'h002);
    tick();

    // Zero-length command is rejected; sticky timeout survives it.
    i_Start = 1'b1; i_Len = '0; i_Act_Base = 10'h155; i_Act_Prec = 2'b11;
    tick();
    i_Start = 1'b0;
    #1;
    check("len0.err", 32'(o_Err), 1);
    check("len0.busy", 32'(o_Busy), 0);
    check("len0.rd", 32'(o_Rd_En), 0);
    check("len0.tmo", 32'(o_Timeout), 1);
    check("len0.prec", 32'(o_Precision), 32'h1);
    tick();
    check("len0.err_clr", 32'(o_Err), 0);
    check("len0.busy2", 32'(o_Busy), 0);
    tick();

    // K=8 accepted (clears timeout), reset asserted after beat 2 is issued.
    run_cmd("k8", 8, 'h050, 'h060, 2, 2, '0, '0, 200, 3,
            128'hE, 128'hC, 128'h4, 0, '0, 0, 3, 0);
    #1 RST = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge CLK) RST = 1'b1;
    tick();
    tick();
    check_all_zero("postrst");

    // Fresh K=2 command after reset, done at n=6, ready at n=7.
    run_cmd("k2", 2, 'h123, 'h0F0, 1, 1, '0, 128'h40, 7, 9,
            128'h6, 128'hC, 128'h4, 4, 128'h80, 8, 7, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
